// File: rtl/exp_seq_25b_if.sv
// Handshake and control bundle between exp_seq_25b and its controller, generator and sink.
// The master modport is the environment side; the slave modport is the sequencer side.
interface exp_seq_25b_if #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 16
);
    logic             i_start;
    logic             i_stop;
    logic [DIV_W-1:0] i_period;
    logic [CNT_W-1:0] i_steps;
    logic [25:0]      i_val;
    logic             o_gen_rst;
    logic             o_tick;
    logic [25:0]      o_data;
    logic             o_valid;
    logic             i_ready;
    logic             o_busy;
    logic             o_done;

    modport master (
        output i_start, i_stop, i_period, i_steps, i_val, i_ready,
        input  o_gen_rst, o_tick, o_data, o_valid, o_busy, o_done
    );

    modport slave (
        input  i_start, i_stop, i_period, i_steps, i_val, i_ready,
        output o_gen_rst, o_tick, o_data, o_valid, o_busy, o_done
    );
endinterface

// File: rtl/exp_seq_25b.sv
// Load/tick sequencer and sample capture stage for gen_exp_25b.
// Optional EXP_SEQ_25B_FREERUN_EN: a latched step count of zero runs until i_stop or reset.
//
// state | meaning
// IDLE  | waiting for i_start
// LOAD  | generator load strobe, divider cleared
// RUN   | divider counting toward the latched period
// HOLD  | period elapsed, waiting for the output slot to free
// DRAIN | last sample captured, waiting for its transfer
module exp_seq_25b #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    exp_seq_25b_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t           state_q;
    logic [DIV_W-1:0] period_q;
    logic [DIV_W-1:0] div_q;
    logic [CNT_W-1:0] remain_q;
    logic [25:0]      data_q;
    logic             valid_q;
    logic             done_q;
    logic             xfer;
    logic             slot_free;
    logic             at_term;
    logic             tick_c;
    logic             last_c;
    logic             abort_c;

`ifdef EXP_SEQ_25B_FREERUN_EN
    logic             free_q;
    assign last_c = !free_q && (remain_q == CNT_W'(1));
`else
    assign last_c = (remain_q == CNT_W'(1));
`endif

    assign xfer      = valid_q && bus.i_ready;
    assign slot_free = !valid_q || bus.i_ready;
    assign at_term   = (div_q == period_q);
    assign abort_c   = bus.i_stop && (state_q != S_IDLE);

    // Tick depends on i_ready so a stalled sample releases the generator in the same cycle.
    assign tick_c = !bus.i_stop && slot_free &&
                    (((state_q == S_RUN) && at_term) || (state_q == S_HOLD));

    assign bus.o_tick    = tick_c;
    assign bus.o_gen_rst = (state_q == S_LOAD) && !bus.i_stop;
    assign bus.o_data    = data_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_busy    = (state_q != S_IDLE);
    assign bus.o_done    = done_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= S_IDLE;
            period_q <= '0;
            div_q    <= '0;
            remain_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
`ifdef EXP_SEQ_25B_FREERUN_EN
            free_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (xfer) begin
                valid_q <= 1'b0;
            end
            // Capture the pre-advance generator value on the tick edge.
            if (tick_c) begin
                data_q  <= bus.i_val;
                valid_q <= 1'b1;
                div_q   <= '0;
`ifdef EXP_SEQ_25B_FREERUN_EN
                if (!free_q) begin
                    remain_q <= remain_q - CNT_W'(1);
                end
`else
                remain_q <= remain_q - CNT_W'(1);
`endif
                state_q <= last_c ? S_DRAIN : S_RUN;
            end

            if (abort_c) begin
                state_q <= S_IDLE;
                valid_q <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (bus.i_start && !bus.i_stop) begin
                            period_q <= bus.i_period;
                            remain_q <= bus.i_steps;
`ifdef EXP_SEQ_25B_FREERUN_EN
                            free_q  <= (bus.i_steps == '0);
                            state_q <= S_LOAD;
`else
                            if (bus.i_steps != '0) begin
                                state_q <= S_LOAD;
                            end else begin
                                done_q <= 1'b1;
                            end
`endif
                        end
                    end
                    S_LOAD: begin
                        div_q   <= '0;
                        state_q <= S_RUN;
                    end
                    S_RUN: begin
                        if (!at_term) begin
                            div_q <= div_q + DIV_W'(1);
                        end else if (!tick_c) begin
                            state_q <= S_HOLD;
                        end
                    end
                    S_HOLD: begin
                    end
                    S_DRAIN: begin
                        if (xfer) begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_exp_seq_25b.sv
// Directed and randomized bench for exp_seq_25b with a ramp/constant generator stub.
// Expectations come from run-level arithmetic: sample k = base + k, tick timing from the period.
module tb_exp_seq_25b;
    localparam logic [25:0] ONE_VAL = 26'h100_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          n_assert = 0;
    int          n_fail = 0;
    logic [25:0] gen_q;
    logic [25:0] gen_base = '0;
    bit          gen_ramp = 1'b0;

    exp_seq_25b_if #(.DIV_W(16), .CNT_W(16)) bus ();

    exp_seq_25b #(.DIV_W(16), .CNT_W(16)) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Generator stub: loads on o_gen_rst, advances on o_tick.
    always @(posedge clk) begin
        if (bus.o_gen_rst) gen_q <= gen_base;
        else if (bus.o_tick && gen_ramp) gen_q <= gen_q + 26'd1;
    end
    assign bus.i_val = gen_ramp ? gen_q : gen_base;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One complete run; rmode 0 = always ready, 1 = six-cycle stall after first capture, 2 = random ready.
    task automatic run_case(input string nm, input int period, input int steps,
                            input bit ramp, input logic [25:0] base, input int rmode);
        int t = 1;
        int tr_idx = 0;
        int n_gr = 0;
        int gr_t = -1;
        int done_t = -1;
        int last_tr = -1;
        int budget;
        bit busy_at_done = 1'b1;
        bit spacing_bad = 1'b0;
        bit stable_bad = 1'b0;
        bit held_v = 1'b0;
        logic [25:0] held = '0;
        logic [25:0] exp_s;
        int ticks[$];

        budget = 40 + steps * (period + 1) * 8;
        gen_base = base;
        gen_ramp = ramp;
        bus.i_period = 16'(period);
        bus.i_steps  = 16'(steps);
        bus.i_ready  = 1'b1;
        bus.i_start  = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        while (done_t < 0 && t < budget) begin
            @(negedge clk);
            if (bus.o_gen_rst) begin n_gr++; gr_t = t; end
            if (bus.o_tick) begin
                if (rmode == 0 && ticks.size() > 0 && t - ticks[$] != period + 1) spacing_bad = 1'b1;
                ticks.push_back(t);
            end
            if (held_v && (!bus.o_valid || bus.o_data !== held)) stable_bad = 1'b1;
            if (bus.o_valid && bus.i_ready) begin
                exp_s = ramp ? base + 26'(tr_idx) : base;
                chk({nm, " sample"}, 32'(bus.o_data), 32'(exp_s));
                tr_idx++;
                last_tr = t;
                held_v = 1'b0;
            end else begin
                held_v = bus.o_valid;
                held = bus.o_data;
            end
            if (bus.o_done) begin done_t = t; busy_at_done = bus.o_busy; end
            @(posedge clk); #1;
            t++;
            case (rmode)
                1:       bus.i_ready = !(ticks.size() > 0 && t > ticks[0] && t <= ticks[0] + 6);
                2:       bus.i_ready = ($urandom_range(0, 2) != 0);
                default: bus.i_ready = 1'b1;
            endcase
        end
        bus.i_ready = 1'b1;
        chk({nm, " finished"}, 32'(done_t >= 0), 32'd1);
        chk({nm, " gen_rst count"}, 32'(n_gr), 32'd1);
        chk({nm, " gen_rst cycle"}, 32'(gr_t), 32'd1);
        chk({nm, " tick count"}, 32'(ticks.size()), 32'(steps));
        chk({nm, " transfers"}, 32'(tr_idx), 32'(steps));
        chk({nm, " first tick"}, 32'(ticks.size() > 0 ? ticks[0] : -1), 32'(period + 2));
        chk({nm, " done after last xfer"}, 32'(done_t), 32'(last_tr + 1));
        chk({nm, " busy low at done"}, 32'(busy_at_done), 32'd0);
        chk({nm, " data stable"}, 32'(stable_bad), 32'd0);
        if (rmode == 0) chk({nm, " tick spacing"}, 32'(spacing_bad), 32'd0);
        if (rmode == 1) chk({nm, " resume tick"}, 32'(ticks.size() > 1 ? ticks[1] : -1),
                            32'(ticks.size() > 0 ? ticks[0] + 7 : -2));
        @(negedge clk);
        chk({nm, " done single"}, 32'(bus.o_done), 32'd0);
        chk({nm, " idle busy"}, 32'(bus.o_busy), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int n_tr;
        int n_tk;
        int n_dn;
        int lim;
        bus.i_start  = 1'b0;
        bus.i_stop   = 1'b0;
        bus.i_period = '0;
        bus.i_steps  = '0;
        bus.i_ready  = 1'b1;
        #1;
        chk("reset valid", 32'(bus.o_valid), 32'd0);
        chk("reset data", 32'(bus.o_data), 32'd0);
        chk("reset busy", 32'(bus.o_busy), 32'd0);
        chk("reset outs", 32'({bus.o_tick, bus.o_gen_rst, bus.o_done}), 32'd0);
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_case("const p3 s4", 3, 4, 1'b0, ONE_VAL, 0);
        run_case("ramp p0 s3", 0, 3, 1'b1, 26'd10, 0);
        run_case("stall p1 s3", 1, 3, 1'b1, 26'd200, 1);
        for (int i = 0; i < 4; i++)
            run_case("random", int'($urandom_range(0, 4)), int'($urandom_range(1, 6)), 1'b1,
                     26'($urandom), 2);

        // Abort after two of five samples.
        gen_base = 26'd100; gen_ramp = 1'b1;
        bus.i_period = 16'd1; bus.i_steps = 16'd5; bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        n_tr = 0;
        lim = 0;
        while (n_tr < 2 && lim < 40) begin
            @(negedge clk);
            if (bus.o_valid && bus.i_ready) n_tr++;
            @(posedge clk); #1;
            lim++;
        end
        chk("stop two xfers seen", 32'(n_tr), 32'd2);
        bus.i_stop = 1'b1;
        @(negedge clk);
        chk("stop tick forced", 32'(bus.o_tick), 32'd0);
        chk("stop gen_rst forced", 32'(bus.o_gen_rst), 32'd0);
        @(posedge clk); #1;
        bus.i_stop = 1'b0;
        @(negedge clk);
        chk("stop busy", 32'(bus.o_busy), 32'd0);
        chk("stop valid", 32'(bus.o_valid), 32'd0);
        n_tk = 0; n_dn = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.o_tick) n_tk++;
            if (bus.o_done) n_dn++;
            @(negedge clk);
        end
        chk("stop no ticks", 32'(n_tk), 32'd0);
        chk("stop no done", 32'(n_dn), 32'd0);
        @(posedge clk); #1;
        run_case("restart p0 s1", 0, 1, 1'b1, 26'd7, 0);

        // Zero step count.
        gen_base = 26'd0; gen_ramp = 1'b1;
        bus.i_period = 16'd0; bus.i_steps = 16'd0; bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
`ifdef EXP_SEQ_25B_FREERUN_EN
        n_tr = 0; n_dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.o_valid && bus.i_ready) begin
                chk("freerun sample", 32'(bus.o_data), 32'(n_tr));
                n_tr++;
            end
            if (bus.o_done) n_dn++;
            @(posedge clk); #1;
        end
        chk("freerun over 20", 32'(n_tr > 20), 32'd1);
        chk("freerun no done", 32'(n_dn), 32'd0);
        bus.i_stop = 1'b1;
        @(posedge clk); #1;
        bus.i_stop = 1'b0;
        @(negedge clk);
        chk("freerun stop busy", 32'(bus.o_busy), 32'd0);
        chk("freerun stop done", 32'(bus.o_done), 32'd0);
`else
        @(negedge clk);
        chk("zero done", 32'(bus.o_done), 32'd1);
        chk("zero gen_rst", 32'(bus.o_gen_rst), 32'd0);
        chk("zero tick", 32'(bus.o_tick), 32'd0);
        chk("zero busy", 32'(bus.o_busy), 32'd0);
        @(negedge clk);
        chk("zero done single", 32'(bus.o_done), 32'd0);
        chk("zero still idle", 32'({bus.o_busy, bus.o_tick, bus.o_gen_rst}), 32'd0);
`endif
        @(posedge clk); #1;

        // Asynchronous reset while a sample is pending.
        gen_base = 26'd55; gen_ramp = 1'b1;
        bus.i_period = 16'd2; bus.i_steps = 16'd5; bus.i_ready = 1'b0; bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        lim = 0;
        while (!bus.o_valid && lim < 30) begin
            @(posedge clk); #1;
            lim++;
        end
        chk("arst valid seen", 32'(bus.o_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst valid", 32'(bus.o_valid), 32'd0);
        chk("arst data", 32'(bus.o_data), 32'd0);
        chk("arst busy", 32'(bus.o_busy), 32'd0);
        chk("arst outs", 32'({bus.o_tick, bus.o_gen_rst, bus.o_done}), 32'd0);
        bus.i_ready = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        n_dn = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.o_done || bus.o_busy) n_dn++;
        end
        chk("arst no done", 32'(n_dn), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
